// File: rtl/vid_pattern_gen.sv
// ============================================================================
// Module   : vid_pattern_gen
// Purpose  : Free-running 1080p video timing generator with four test patterns.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module vid_pattern_gen #(
  parameter int H_TOTAL      = 2200,
  parameter int H_SYNC_START = 88,
  parameter int H_SYNC_END   = 131,
  parameter int H_ACT_START  = 280,
  parameter int V_TOTAL      = 1125,
  parameter int V_SYNC_START = 4,
  parameter int V_SYNC_END   = 8,
  parameter int V_ACT_START  = 45
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic [1:0]  pat_sel,
  output logic [23:0] o_vid_data,
  output logic        o_vid_hsync,
  output logic        o_vid_vsync,
  output logic        o_vid_VDE,
  output logic        o_frame_start,
  output logic [7:0]  o_frame_cnt
);

  logic [11:0] h_cnt;
  logic [10:0] v_cnt;
  logic [7:0]  frame_cnt;
  logic [1:0]  pat;

  logic        h_last;
  logic        v_last;
  logic        at_origin;
  logic        hsync;
  logic        vsync;
  logic        vde;
  logic [11:0] h_off;
  logic [10:0] v_off;
  logic [10:0] x;
  logic [10:0] y;
  logic [2:0]  bar;
  logic [23:0] bar_rgb;
  logic [23:0] pix;

  assign h_last    = (h_cnt == 12'(H_TOTAL - 1));
  assign v_last    = (v_cnt == 11'(V_TOTAL - 1));
  assign at_origin = (h_cnt == 12'd0) && (v_cnt == 11'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt     <= '0;
      v_cnt     <= '0;
      frame_cnt <= '0;
      pat       <= '0;
    end else if (ce) begin
      // Pattern is latched only at the frame origin so a mid-frame change never tears.
      if (at_origin)
        pat <= pat_sel;
      if (h_last) begin
        h_cnt <= '0;
        if (v_last) begin
          v_cnt     <= '0;
          frame_cnt <= frame_cnt + 8'd1;
        end else begin
          v_cnt <= v_cnt + 11'd1;
        end
      end else begin
        h_cnt <= h_cnt + 12'd1;
      end
    end
  end

  assign hsync = (h_cnt >= 12'(H_SYNC_START)) && (h_cnt <= 12'(H_SYNC_END));
  assign vsync = (v_cnt >= 11'(V_SYNC_START)) && (v_cnt <= 11'(V_SYNC_END));
  assign vde   = (h_cnt >= 12'(H_ACT_START)) && (v_cnt >= 11'(V_ACT_START));
  assign h_off = h_cnt - 12'(H_ACT_START);
  assign v_off = v_cnt - 11'(V_ACT_START);
  assign x     = vde ? h_off[10:0] : 11'd0;
  assign y     = vde ? v_off : 11'd0;

  // Bar index x/240 via a compare chain; no divider.
  always_comb begin
    bar = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (x >= 11'(240 * i))
        bar = 3'(i);
    end
  end

  always_comb begin
    bar_rgb = 24'h000000;
    case (bar)
      3'd0:    bar_rgb = 24'hFFFFFF;
      3'd1:    bar_rgb = 24'hFFFF00;
      3'd2:    bar_rgb = 24'h00FFFF;
      3'd3:    bar_rgb = 24'h00FF00;
      3'd4:    bar_rgb = 24'hFF00FF;
      3'd5:    bar_rgb = 24'hFF0000;
      3'd6:    bar_rgb = 24'h0000FF;
      default: bar_rgb = 24'h000000;
    endcase
  end

  always_comb begin
    pix = 24'h000000;
    if (vde) begin
      case (pat)
        2'd0:    pix = bar_rgb;
        2'd1:    pix = {3{x[10:3]}};
        2'd2:    pix = (x[6] ^ y[6]) ? 24'hFFFFFF : 24'h000000;
        default: pix = {x[7:0] + frame_cnt, y[7:0], frame_cnt};
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_vid_data    <= '0;
      o_vid_hsync   <= 1'b0;
      o_vid_vsync   <= 1'b0;
      o_vid_VDE     <= 1'b0;
      o_frame_start <= 1'b0;
      o_frame_cnt   <= '0;
    end else if (ce) begin
      o_vid_data    <= pix;
      o_vid_hsync   <= hsync;
      o_vid_vsync   <= vsync;
      o_vid_VDE     <= vde;
      o_frame_start <= at_origin;
      o_frame_cnt   <= frame_cnt;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_vid_pattern_gen.sv
// ============================================================================
// Module   : tb_vid_pattern_gen
// Purpose  : Checks three vid_pattern_gen instances against a position model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_vid_pattern_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ce = 1'b0;
  logic [1:0] pat_sel = 2'd0;

  int errors = 0;
  int checks = 0;

  // A: full-width lines, few rows.  B: narrow, tall frame.  C: native 1080p.
  localparam int AH = 1940, AHS = 4, AHE = 9, AHA = 20, AV = 6,    AVS = 1, AVE = 1, AVA = 2;
  localparam int BH = 80,   BHS = 2, BHE = 5, BHA = 10, BV = 80,   BVS = 1, BVE = 2, BVA = 4;
  localparam int CH = 2200, CHS = 88, CHE = 131, CHA = 280, CV = 1125, CVS = 4, CVE = 8, CVA = 45;

  logic [23:0] da, db, dc;
  logic        hsa, hsb, hsc, vsa, vsb, vsc, dea, deb, dec, fsa, fsb, fsc;
  logic [7:0]  fca, fcb, fcc;

  vid_pattern_gen #(.H_TOTAL(AH), .H_SYNC_START(AHS), .H_SYNC_END(AHE), .H_ACT_START(AHA),
                    .V_TOTAL(AV), .V_SYNC_START(AVS), .V_SYNC_END(AVE), .V_ACT_START(AVA))
  u_a (.clk(clk), .rst(rst), .ce(ce), .pat_sel(pat_sel), .o_vid_data(da), .o_vid_hsync(hsa),
       .o_vid_vsync(vsa), .o_vid_VDE(dea), .o_frame_start(fsa), .o_frame_cnt(fca));

  vid_pattern_gen #(.H_TOTAL(BH), .H_SYNC_START(BHS), .H_SYNC_END(BHE), .H_ACT_START(BHA),
                    .V_TOTAL(BV), .V_SYNC_START(BVS), .V_SYNC_END(BVE), .V_ACT_START(BVA))
  u_b (.clk(clk), .rst(rst), .ce(ce), .pat_sel(pat_sel), .o_vid_data(db), .o_vid_hsync(hsb),
       .o_vid_vsync(vsb), .o_vid_VDE(deb), .o_frame_start(fsb), .o_frame_cnt(fcb));

  vid_pattern_gen u_c (.clk(clk), .rst(rst), .ce(ce), .pat_sel(pat_sel), .o_vid_data(dc),
       .o_vid_hsync(hsc), .o_vid_vsync(vsc), .o_vid_VDE(dec), .o_frame_start(fsc), .o_frame_cnt(fcc));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [35:0] got, input logic [35:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Expected {data,hsync,vsync,VDE,frame_start,frame_cnt} after n pixel-enable edges.
  function automatic logic [35:0] model(int n, int ht, int hss, int hse, int has,
                                        int vt, int vss, int vse, int vas, logic [1:0] p);
    int q, fs, pos, h, v, x, y, fc;
    logic hs, vs, de;
    logic [23:0] d;
    if (n == 0) return '0;
    fs  = ht * vt;
    q   = n - 1;
    pos = q % fs;
    h   = pos % ht;
    v   = pos / ht;
    fc  = (q / fs) % 256;
    hs  = (h >= hss) && (h <= hse);
    vs  = (v >= vss) && (v <= vse);
    de  = (h >= has) && (v >= vas);
    x   = de ? h - has : 0;
    y   = de ? v - vas : 0;
    d   = 24'h0;
    if (de) begin
      case (p)
        2'd0: case (x / 240)
                0: d = 24'hFFFFFF; 1: d = 24'hFFFF00; 2: d = 24'h00FFFF; 3: d = 24'h00FF00;
                4: d = 24'hFF00FF; 5: d = 24'hFF0000; 6: d = 24'h0000FF; default: d = 24'h000000;
              endcase
        2'd1: d = {3{8'((x / 8) % 256)}};
        2'd2: d = (((x / 64) % 2) != ((y / 64) % 2)) ? 24'hFFFFFF : 24'h000000;
        default: d = {8'((x + fc) % 256), 8'(y % 256), 8'(fc)};
      endcase
    end
    return {d, hs, vs, de, (pos == 0), 8'(fc)};
  endfunction

  int na = 0, nb = 0, nc = 0;
  logic [1:0] pa = 2'd0, pb = 2'd0, pc = 2'd0;
  int hs_cnt_c = 0;
  logic [23:0] data_or_c = 24'h0;

  task automatic check_all();
    check("A", {da, hsa, vsa, dea, fsa, fca}, model(na, AH, AHS, AHE, AHA, AV, AVS, AVE, AVA, pa));
    check("B", {db, hsb, vsb, deb, fsb, fcb}, model(nb, BH, BHS, BHE, BHA, BV, BVS, BVE, BVA, pb));
    check("C", {dc, hsc, vsc, dec, fsc, fcc}, model(nc, CH, CHS, CHE, CHA, CV, CVS, CVE, CVA, pc));
  endtask

  // Called at a falling edge: apply inputs, advance the model, check after the next edge.
  task automatic step(input logic c, input logic [1:0] ps);
    ce = c;
    pat_sel = ps;
    if (c) begin
      if (na % (AH * AV) == 0) pa = ps;
      if (nb % (BH * BV) == 0) pb = ps;
      if (nc % (CH * CV) == 0) pc = ps;
      na++; nb++; nc++;
    end
    @(negedge clk);
    check_all();
  endtask

  initial begin
    @(negedge clk);
    check_all();
    rst = 1'b0;

    // First native line: exact hsync window, no active video.
    for (int k = 1; k <= 2200; k++) begin
      step(1'b1, 2'd0);
      if (hsc) hs_cnt_c++;
      data_or_c |= dc;
      if (k == 1) check("fs_first_edge", 36'(fsc), 36'd1);
      if (k == 88 || k == 89 || k == 132 || k == 133)
        check("hsync_edge", 36'(hsc), 36'((k >= 89) && (k <= 132)));
    end
    check("hsync_count_line0", 36'(hs_cnt_c), 36'd44);
    check("data_line0", 36'(data_or_c), 36'd0);

    // Free-running with pattern changes landing mid-frame.
    for (int k = 0; k < 12000; k++) step(1'b1, 2'd0);
    for (int k = 0; k < 13000; k++) step(1'b1, 2'd2);
    for (int k = 0; k < 12000; k++) step(1'b1, 2'd1);

    // Random stalls with the animated pattern.
    for (int k = 0; k < 30000; k++) step(1'($urandom_range(0, 1)), 2'd3);
    for (int k = 0; k < 2000; k++)  step(1'($urandom_range(0, 3) != 0), 2'($urandom));

    // Asynchronous reset mid-line on instance A at h = 1000.
    begin
      int guard = 0;
      while (((na - 1) % AH) != 1000 && guard < 5000) begin
        step(1'b1, 2'd0);
        guard++;
      end
      check("reach_h1000", 36'(guard < 5000), 36'd1);
    end
    #2 rst = 1'b1;
    #1;
    check("rst_A", {da, hsa, vsa, dea, fsa, fca}, 36'd0);
    check("rst_B", {db, hsb, vsb, deb, fsb, fcb}, 36'd0);
    check("rst_C", {dc, hsc, vsc, dec, fsc, fcc}, 36'd0);
    na = 0; nb = 0; nc = 0;
    repeat (2) @(negedge clk);
    check_all();
    rst = 1'b0;
    for (int k = 0; k < 3000; k++) step(1'($urandom_range(0, 4) != 0), 2'($urandom));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/vid_pattern_gen.md
# vid_pattern_gen

- Free-running 1080p video timing generator with a built-in test-pattern source.
- Sits directly upstream of `colour_change` and drives its `i_vid_data`, `i_vid_hsync`, `i_vid_vsync` and `i_vid_VDE` inputs.
- Lets the colour stage be exercised on hardware and in simulation without an HDMI source.
- Produces 2200×1125 total / 1920×1080 active frames with four selectable patterns, one of which is animated per frame.

## Interface
- `H_TOTAL`, 2200: pixels per line, including blanking.
- `H_SYNC_START`, 88: first h-count with hsync high.
- `H_SYNC_END`, 131: last h-count with hsync high.
- `H_ACT_START`, 280: first active h-count; active region runs to `H_TOTAL-1`.
- `V_TOTAL`, 1125: lines per frame.
- `V_SYNC_START`, 4: first v-count with vsync high.
- `V_SYNC_END`, 8: last v-count with vsync high.
- `V_ACT_START`, 45: first active line; active region runs to `V_TOTAL-1`.
- `clk` in, 1: pixel clock; all logic on rising edge.
- `rst` in, 1: asynchronous, active-high reset.
- `ce` in, 1: pixel enable; when low, all state and outputs hold.
- `pat_sel` in, 2: pattern request; sampled at frame start only.
- `o_vid_data` out, 24: pixel, R[23:16] G[15:8] B[7:0].
- `o_vid_hsync` out, 1: horizontal sync, active-high.
- `o_vid_vsync` out, 1: vertical sync, active-high.
- `o_vid_VDE` out, 1: data enable, high in the active region only.
- `o_frame_start` out, 1: one-cycle pulse when the registered position is (0,0).
- `o_frame_cnt` out, 8: frames completed since reset, wrapping.

## Operation
- Counters:
  - `h_cnt` (12 b) increments on each `ce` cycle; at `H_TOTAL-1` it wraps to 0 and `v_cnt` (11 b) increments.
  - `v_cnt` wraps to 0 at `V_TOTAL-1` when `h_cnt` also wraps; `frame_cnt` then increments mod 256.
- Decode from the current counter value, registered into the outputs:
  - hsync = `H_SYNC_START ≤ h ≤ H_SYNC_END`.
  - vsync = `V_SYNC_START ≤ v ≤ V_SYNC_END`.
  - VDE = `h ≥ H_ACT_START` and `v ≥ V_ACT_START`.
- Active coordinates: x = h − `H_ACT_START` (0..1919), y = v − `V_ACT_START` (0..1079); both zero outside the active region.
- Pattern register `pat` loads `pat_sel` when (h,v) = (0,0) and `ce` is high; held for the whole frame. A change mid-frame never tears.
- Patterns (data forced to 0x000000 whenever VDE is 0):
  - 0, colour bars: eight bars 240 px wide, index = x/240. Order: FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000.
  - 1, grey ramp: R = G = B = x[10:3] (0..239 across the line).
  - 2, checkerboard: 64×64 squares; FFFFFF when x[6] XOR y[6] is 1, else 000000.
  - 3, scrolling: R = (x[7:0] + frame_cnt) mod 256, G = y[7:0], B = frame_cnt.
- Division by 240 uses a compare chain or a per-line bar counter. A runtime divider is not allowed.

## Timing
- Reset state:
  - h_cnt, v_cnt, frame_cnt and pat are 0.
  - All outputs are 0, including `o_vid_data` = 0x000000 and `o_frame_start` = 0.
- Latency is exactly 1 `ce` cycle from counter value to outputs. Data, syncs, VDE and frame_start always describe the same pixel; no skew between them is permitted.
- After reset release, on the k-th `ce` rising edge the outputs reflect h = k−1, v = 0:
  - `o_frame_start` is high after edge 1.
  - hsync is high after edges 89..132 (44 cycles).
- `o_frame_cnt` is the registered frame_cnt, aligned with the pixel shown. It increments on the edge where the outputs show (0,0).
- `ce` low: counters, pat, frame_cnt and every output hold their value. `o_frame_start` stays high if it was high, with no second increment. It is not re-pulsed when `ce` returns.
- `rst` mid-frame: outputs go to 0 immediately (asynchronous). Counting restarts at (0,0) on the first `ce` edge after release.
- Per frame: hsync 44 clk/line, vsync 5 lines, VDE 1920 × 1080 = 2073600 cycles.

## Test plan
- Reset then 2200 `ce` cycles, `pat_sel` = 0:
  - hsync high exactly after edges 89..132.
  - VDE low for the whole first line (v = 0 is in blanking).
  - `o_vid_data` = 0 throughout.
- One full frame, `pat_sel` = 0:
  - VDE count = 2073600; hsync line count = 1125; vsync high for lines 4..8.
  - Line 45: x = 0 gives FFFFFF, x = 240 gives FFFF00, x = 1919 gives 000000.
- `pat_sel` changed 0→2 mid-frame:
  - Colour bars continue to frame end.
  - Next frame: pixel (x, y) = (64, 0) is FFFFFF and (64, 64) is 000000.
- `pat_sel` = 3 over 3 frames:
  - Pixel (x, y) = (10, 5) reads R = 10 + f, G = 5, B = f for f = 0, 1, 2.
  - `o_frame_cnt` steps 0→1→2 coincident with `o_frame_start`.
- `ce` toggled 1/0 randomly:
  - Output sequence with stalls removed is identical to the free-running run.
  - No output changes while `ce` = 0.
- Assert `rst` at (h, v) = (1000, 500):
  - All outputs are 0 before the next clock edge.
  - After release, hsync is next high after edges 89..132 of the new count.
